// File: rtl/ram_wr_ctrl.sv
// Write-side controller for the dual-port RAM test design.
// Waits START_DLY cycles after reset, then writes frame after frame of DEPTH
// words into RAM port A. Each frame's data is offset by the frame counter so the
// reader can tell which frame it sees. Handshake: rd_start pulse out, rd_done level in.
module ram_wr_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int START_DLY = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              rd_done,
  output logic              ram_wr_en,
  output logic              ram_wr_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              rd_start,
  output logic              wr_busy,
  output logic [DATA_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {DLY, WRITE, HAND, WAIT_RD} state_t;

  localparam int                DLY_W     = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(START_DLY - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [DLY_W-1:0]    dly_cnt, dly_nxt;
  logic                en_nxt, rs_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt, fcnt_nxt;

  // State and all outputs are registered; the comb block computes their next values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= DLY;
      dly_cnt     <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_we   <= 1'b0;
      wr_busy     <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      rd_start    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      dly_cnt     <= dly_nxt;
      ram_wr_en   <= en_nxt;
      ram_wr_we   <= en_nxt;
      wr_busy     <= en_nxt;
      ram_wr_addr <= addr_nxt;
      ram_wr_data <= data_nxt;
      rd_start    <= rs_nxt;
      frame_cnt   <= fcnt_nxt;
    end
  end

  // Next-state and next-output logic. Outputs reflect the state being entered,
  // so the first write is visible right after the edge that leaves DLY/WAIT_RD.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    en_nxt    = 1'b0;
    rs_nxt    = 1'b0;
    addr_nxt  = ram_wr_addr;
    fcnt_nxt  = frame_cnt;
    case (state)
      DLY: begin
        if (dly_cnt == DLY_LAST) begin
          state_nxt = WRITE;
          en_nxt    = 1'b1;
          addr_nxt  = '0;
        end else begin
          dly_nxt = dly_cnt + DLY_W'(1);
        end
      end
      WRITE: begin
        if (ram_wr_addr == ADDR_LAST) begin
          state_nxt = HAND;
          rs_nxt    = 1'b1;
        end else begin
          en_nxt   = 1'b1;
          addr_nxt = ram_wr_addr + ADDR_W'(1);
        end
      end
      HAND: state_nxt = WAIT_RD;
      WAIT_RD: begin
        // rd_done is only looked at here; a level still high on entry is accepted.
        if (rd_done) begin
          state_nxt = WRITE;
          en_nxt    = 1'b1;
          addr_nxt  = '0;
          fcnt_nxt  = frame_cnt + DATA_W'(1);
        end
      end
      default: state_nxt = DLY;
    endcase
    // Data tracks the address being presented; outside WRITE it simply holds.
    data_nxt = fcnt_nxt + DATA_W'(addr_nxt);
  end

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Scoreboard bench for ram_wr_ctrl: stimulus pushes expected write/rd_start
// events (with their cycle number), a negedge monitor pops and compares.
module tb_ram_wr_ctrl;

  logic       sys_clk, sys_rst_n, rd_done;
  logic       ram_wr_en, ram_wr_we, rd_start, wr_busy;
  logic [4:0] ram_wr_addr;
  logic [7:0] ram_wr_data, frame_cnt;

  // Corner instance: DEPTH = 1, START_DLY = 1, reader never answers.
  logic       rd_done1, en1, we1, rs1, busy1;
  logic [4:0] addr1;
  logic [7:0] data1, fcnt1;

  ram_wr_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .START_DLY(10)) u0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rd_done(rd_done),
    .ram_wr_en(ram_wr_en), .ram_wr_we(ram_wr_we), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .rd_start(rd_start), .wr_busy(wr_busy),
    .frame_cnt(frame_cnt));

  ram_wr_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(1), .START_DLY(1)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rd_done(rd_done1),
    .ram_wr_en(en1), .ram_wr_we(we1), .ram_wr_addr(addr1),
    .ram_wr_data(data1), .rd_start(rs1), .wr_busy(busy1),
    .frame_cnt(fcnt1));

  typedef struct {
    int kind;   // 1 = write, 2 = rd_start
    int cyc;
    int addr;
    int data;
    int fcnt;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Edge counter: after edge k following reset release, cyc == k.
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected events of frame k starting at cycle t; n < 32 truncates the frame.
  task automatic push_frame(input int k, input int t, input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.kind = 1; e.cyc = t + i; e.addr = i; e.data = (k + i) % 256; e.fcnt = k % 256;
      q.push_back(e);
    end
    if (n == 32) begin
      e.kind = 2; e.cyc = t + 32; e.addr = 0; e.data = 0; e.fcnt = k % 256;
      q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge sys_clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_en"},   ram_wr_en,   0);
    chk({nm, "_we"},   ram_wr_we,   0);
    chk({nm, "_addr"}, ram_wr_addr, 0);
    chk({nm, "_data"}, ram_wr_data, 0);
    chk({nm, "_rs"},   rd_start,    0);
    chk({nm, "_busy"}, wr_busy,     0);
    chk({nm, "_fcnt"}, frame_cnt,   0);
  endtask

  // Monitor: every presented write / rd_start must match the queue head.
  always @(negedge sys_clk) begin
    ev_t e;
    if (sys_rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cyc", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (ram_wr_en || rd_start) begin
        if (q.size() == 0) chk("unexpected_event_cyc", cyc, -1);
        else begin
          e = q.pop_front();
          chk("ev_kind", int'({rd_start, ram_wr_en}), e.kind);
          chk("ev_cyc", cyc, e.cyc);
          if (e.kind == 1) begin
            chk("wr_addr", ram_wr_addr, e.addr);
            chk("wr_data", ram_wr_data, e.data);
          end
          chk("ev_fcnt", frame_cnt, e.fcnt);
        end
      end
      chk("we_eq_en", ram_wr_we, ram_wr_en);
      chk("busy_eq_en", wr_busy, ram_wr_en);
    end
  end

  initial begin
    int t;
    sys_rst_n = 1'b0;
    rd_done   = 1'b0;
    rd_done1  = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk_all_zero("reset");
    chk("reset_en1", en1, 0);

    // First frame after reset, reader idle.
    sys_rst_n = 1'b1;
    push_frame(0, 10, 32);

    wait_cyc(1);
    chk("c_en_e1",   en1,   1);
    chk("c_addr_e1", addr1, 0);
    chk("c_data_e1", data1, 0);
    chk("c_busy_e1", busy1, 1);
    chk("c_rs_e1",   rs1,   0);
    wait_cyc(2);
    chk("c_en_e2",   en1,   0);
    chk("c_rs_e2",   rs1,   1);
    chk("c_busy_e2", busy1, 0);
    wait_cyc(3);
    chk("c_rs_e3",   rs1,   0);
    chk("c_busy_e3", busy1, 0);
    chk("c_fcnt_e3", fcnt1, 0);

    wait_cyc(9);
    chk_all_zero("dly_e9");

    // Handshake: one-cycle rd_done 5 cycles after rd_start (cycle 42).
    wait_cyc(46);
    chk("idle_fcnt", frame_cnt, 0);
    rd_done = 1'b1;
    push_frame(1, 47, 32);
    wait_cyc(47);
    rd_done = 1'b0;
    chk("hs_fcnt", frame_cnt, 1);
    chk("hs_data", ram_wr_data, 1);

    // Held rd_done: back-to-back frames 34 cycles apart, through the 8-bit wrap.
    wait_cyc(85);
    rd_done = 1'b1;
    t = 86;
    for (int k = 2; k <= 256; k++) begin
      push_frame(k, t, 32);
      t += 34;
    end
    wait_cyc(86 + 228 * 34 + 26);     // frame 230, addr 26
    chk("wrap_addr", ram_wr_addr, 26);
    chk("wrap_data", ram_wr_data, 0);
    wait_cyc(86 + 254 * 34 + 32);     // rd_start of frame 256
    rd_done = 1'b0;
    wait_cyc(86 + 254 * 34 + 38);
    chk("fcnt_wrap", frame_cnt, 0);
    chk("q_empty_1", q.size(), 0);
    chk("idle_en", ram_wr_en, 0);

    // Reset from idle clears held addr/data asynchronously.
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("rst_idle");
    @(negedge sys_clk);

    // Reset mid-frame: rd_done held high, drop reset at addr 17 of frame 3.
    rd_done   = 1'b1;
    sys_rst_n = 1'b1;
    push_frame(0, 10, 32);
    push_frame(1, 44, 32);
    push_frame(2, 78, 32);
    push_frame(3, 112, 18);
    wait_cyc(129);
    #2;
    chk("mid_addr_pre", ram_wr_addr, 17);
    chk("mid_fcnt_pre", frame_cnt, 3);
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    chk("q_empty_2", q.size(), 0);
    @(negedge sys_clk);

    // After release: full delay again, then frame 0 with data 0..31.
    rd_done   = 1'b0;
    sys_rst_n = 1'b1;
    push_frame(0, 10, 32);
    wait_cyc(9);
    chk_all_zero("redly_e9");
    wait_cyc(45);
    chk("re_fcnt", frame_cnt, 0);
    chk("q_empty_3", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got %0d expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
